// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_ctrl
//  Purpose  : Data-memory access controller. Round-robin arbitration between
//             the CPU port (A) and the program-loader port (B) onto a single
//             synchronous-read word RAM, with byte-enable stores implemented
//             as a read-modify-write sequence.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_ctrl #(
   parameter int ADDR_W = 14
) (
   input  logic              clock,
   input  logic              reset,

   // CPU load/store port
   input  logic              a_req,
   input  logic              a_we,
   input  logic [3:0]        a_be,
   input  logic [31:0]       a_addr,
   input  logic [31:0]       a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [31:0]       a_rdata,

   // Program-loader port (full-word writes only)
   input  logic              b_req,
   input  logic              b_we,
   input  logic [31:0]       b_addr,
   input  logic [31:0]       b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [31:0]       b_rdata,

   // Single-port data RAM
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,

   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_DATA = 2'd1,
      ST_RMW     = 2'd2
   } state_t;

   localparam logic [3:0] BE_FULL = 4'hF;
   localparam logic [3:0] BE_NONE = 4'h0;

   state_t              state_q,   state_d;
   logic                last_b_q,  last_b_d;   // 1: port B was served last
   logic                owner_b_q, owner_b_d;  // 1: current access belongs to B
   logic [ADDR_W-1:0]   addr_q,    addr_d;
   logic [31:0]         wdata_q,   wdata_d;
   logic [3:0]          be_q,      be_d;
   logic [31:0]         a_rdata_q, a_rdata_d;
   logic [31:0]         b_rdata_q, b_rdata_d;

   logic                a_win;
   logic                b_win;
   logic [ADDR_W-1:0]   a_word;
   logic [ADDR_W-1:0]   b_word;
   logic [31:0]         rmw_merged;
   logic                unused_addr_bits;

   // Byte offset and bits above the RAM range carry no meaning here.
   assign a_word = a_addr[ADDR_W+1:2];
   assign b_word = b_addr[ADDR_W+1:2];
   assign unused_addr_bits = ^{a_addr[31:ADDR_W+2], a_addr[1:0],
                               b_addr[31:ADDR_W+2], b_addr[1:0]};

   // Merge the latched store bytes over the word just read back from RAM.
   for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign rmw_merged[8*gi +: 8] = be_q[gi] ? wdata_q[8*gi +: 8]
                                              : ram_dout[8*gi +: 8];
   end

   // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
   always_comb begin
      a_win = 1'b0;
      b_win = 1'b0;
      if (!reset && state_q == ST_IDLE) begin
         if (a_req && (!b_req || last_b_q)) begin
            a_win = 1'b1;
         end else if (b_req) begin
            b_win = 1'b1;
         end
      end
   end

   // Next-state and RAM/port outputs; everything is quiet while reset is high.
   always_comb begin
      state_d   = state_q;
      last_b_d  = last_b_q;
      owner_b_d = owner_b_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      a_rvalid  = 1'b0;
      b_rvalid  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;

      if (!reset) begin
         case (state_q)
            ST_IDLE: begin
               if (a_win) begin
                  a_gnt     = 1'b1;
                  last_b_d  = 1'b0;
                  owner_b_d = 1'b0;
                  addr_d    = a_word;
                  wdata_d   = a_wdata;
                  be_d      = a_be;
                  ram_addr  = a_word;
                  if (!a_we) begin
                     state_d = ST_RD_DATA;
                  end else if (a_be == BE_FULL) begin
                     ram_we  = 1'b1;
                     ram_din = a_wdata;
                  end else if (a_be != BE_NONE) begin
                     // Partial store: this cycle fetches the old word.
                     state_d = ST_RMW;
                  end
               end else if (b_win) begin
                  b_gnt     = 1'b1;
                  last_b_d  = 1'b1;
                  owner_b_d = 1'b1;
                  addr_d    = b_word;
                  wdata_d   = b_wdata;
                  be_d      = BE_FULL;
                  ram_addr  = b_word;
                  if (!b_we) begin
                     state_d = ST_RD_DATA;
                  end else begin
                     ram_we  = 1'b1;
                     ram_din = b_wdata;
                  end
               end
            end

            ST_RD_DATA: begin
               if (owner_b_q) begin
                  b_rvalid  = 1'b1;
                  b_rdata_d = ram_dout;
               end else begin
                  a_rvalid  = 1'b1;
                  a_rdata_d = ram_dout;
               end
               state_d = ST_IDLE;
            end

            ST_RMW: begin
               ram_we   = 1'b1;
               ram_addr = addr_q;
               ram_din  = rmw_merged;
               state_d  = ST_IDLE;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Read data is live from the RAM in the return cycle, then held.
   assign a_rdata = a_rvalid ? ram_dout : a_rdata_q;
   assign b_rdata = b_rvalid ? ram_dout : b_rdata_q;
   assign busy    = (state_q != ST_IDLE);

   // State and capture registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         last_b_q  <= 1'b1;
         owner_b_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         last_b_q  <= last_b_d;
         owner_b_q <= owner_b_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

endmodule
`default_nettype wire
